// File: rtl/seeg_axil_regfile.sv
`default_nettype none
// ============================================================================
// Module  : seeg_axil_regfile
// Brief   : AXI4-Lite slave register file for the sEEG top. It holds the
//           command word and the configuration words, drives them flat to the
//           record/stim/zcheck controllers, and returns live status on reads.
//           A 0->1 edge on a low command bit yields a one-cycle strobe.
// Ports   : S_AXI_*    AXI4-Lite slave (ACLK, async active-low ARESETN)
//           status_in  live status word, readable at word 1
//           cfg_flat   all register words, word n at [n*32 +: 32]
//           cmd_pulse  one-cycle command strobes (bits 0..CMD_BITS-1)
// Map     : 0 command (RW), 1 status (RO), 2 VERSION (RO), 3.. config (RW)
// Rev     : 1.0  initial release
// ============================================================================
module seeg_axil_regfile #(
  parameter int          NUM_REGS = 32,
  parameter int          ADDR_W   = 7,
  parameter int          CMD_BITS = 9,
  parameter logic [31:0] VERSION  = 32'h0001_0000
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  input  logic [31:0]              status_in,
  output logic [NUM_REGS*32-1:0]   cfg_flat,
  output logic [CMD_BITS-1:0]      cmd_pulse
);

  localparam int          WORD_W      = ADDR_W - 2;
  localparam logic [31:0] NUM_REGS_W  = 32'(NUM_REGS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // Handshake / response state
  logic                awready_q;   // shared AWREADY/WREADY pulse
  logic                bvalid_q;
  logic [1:0]          bresp_q;
  logic                arready_q;
  logic                rvalid_q;
  logic [1:0]          rresp_q;
  logic [31:0]         rdata_q;
  logic [CMD_BITS-1:0] cmd_pulse_q;

  logic [WORD_W-1:0]   w_aw_word;
  logic [WORD_W-1:0]   w_ar_word;
  logic                w_aw_ok;
  logic                w_ar_ok;
  logic [31:0]         w_rdata_d;
  logic [31:0]         w_word [NUM_REGS];
  logic                w_unused;

  assign w_aw_word = S_AXI_AWADDR[ADDR_W-1:2];
  assign w_ar_word = S_AXI_ARADDR[ADDR_W-1:2];
  assign w_aw_ok   = (32'(w_aw_word) < NUM_REGS_W);
  assign w_ar_ok   = (32'(w_ar_word) < NUM_REGS_W);
  // Byte offset bits are don't-care: every access is a full word.
  assign w_unused  = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // --------------------------------------------------------------------------
  // Write/read handshakes. A READY pulse is raised only when the channel is
  // idle, so the cycle in which READY is high is the handshake (commit) cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      awready_q <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
      if (awready_q) begin
        bvalid_q <= 1'b1;
        bresp_q  <= w_aw_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end

      arready_q <= S_AXI_ARVALID && !rvalid_q && !arready_q;
      if (arready_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= w_rdata_d;
        rresp_q  <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Read mux sees the pre-commit register value, so a same-cycle read of a
  // word being written returns the old contents.
  always_comb begin
    w_rdata_d = '0;
    if (w_ar_ok) begin
      for (int n = 0; n < NUM_REGS; n++) begin
        if (w_ar_word == WORD_W'(n)) w_rdata_d = w_word[n];
      end
      if (w_ar_word == WORD_W'(1)) w_rdata_d = status_in;
    end
  end

  // --------------------------------------------------------------------------
  // Register words. Words 1 and 2 have no storage: status is read live and
  // VERSION is a constant; writes to them are accepted and discarded.
  // --------------------------------------------------------------------------
  for (genvar n = 0; n < NUM_REGS; n++) begin : g_word
    if (n == 1) begin : g_status
      assign w_word[n] = '0;
    end else if (n == 2) begin : g_version
      assign w_word[n] = VERSION;
    end else begin : g_rw
      logic        hit;
      logic [31:0] word_q;
      logic [31:0] word_d;

      assign hit = awready_q && (w_aw_word == WORD_W'(n));

      always_comb begin
        word_d = word_q;
        if (hit) begin
          for (int k = 0; k < 4; k++) begin
            if (S_AXI_WSTRB[k]) word_d[8*k +: 8] = S_AXI_WDATA[8*k +: 8];
          end
        end
      end

      always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) word_q <= '0;
        else                word_q <= word_d;
      end

      assign w_word[n] = word_q;

      if (n == 0) begin : g_cmd
        // Strobe only on rising command bits of a committed write.
        always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
          if (!S_AXI_ARESETN) cmd_pulse_q <= '0;
          else if (hit)       cmd_pulse_q <= word_d[CMD_BITS-1:0] & ~word_q[CMD_BITS-1:0];
          else                cmd_pulse_q <= '0;
        end
      end
    end

    assign cfg_flat[n*32 +: 32] = w_word[n];
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign cmd_pulse     = cmd_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_seeg_axil_regfile.sv
`default_nettype none
// ============================================================================
// Module  : tb_seeg_axil_regfile
// Brief   : Self-checking bench for seeg_axil_regfile with queued expected
//           B and R responses compared when the DUT presents them.
// Rev     : 1.0  initial release
// ============================================================================
module tb_seeg_axil_regfile;

  localparam int          NUM_REGS = 32;
  localparam int          ADDR_W   = 8;
  localparam int          CMD_BITS = 9;
  localparam logic [31:0] VERSION  = 32'h0001_0000;
  localparam int          TMO      = 50;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic [ADDR_W-1:0]      awaddr, araddr;
  logic                   awvalid, wvalid, bready, arvalid, rready;
  logic                   awready, wready, bvalid, arready, rvalid;
  logic [31:0]            wdata, rdata, status;
  logic [3:0]             wstrb;
  logic [1:0]             bresp, rresp;
  logic [NUM_REGS*32-1:0] cfg;
  logic [CMD_BITS-1:0]    cmd_pulse;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int pulse_cnt [CMD_BITS];
  int aw_hs_cnt = 0;
  logic [CMD_BITS-1:0] wr_pulse;
  logic [1:0]  exp_b_q [$];
  logic [33:0] exp_r_q [$];

  always #5 clk = ~clk;

  seeg_axil_regfile #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .CMD_BITS (CMD_BITS),
    .VERSION  (VERSION)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rstn),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .status_in     (status),
    .cfg_flat      (cfg),
    .cmd_pulse     (cmd_pulse)
  );

  // Cycle counters sampled on the falling edge, away from the active edge.
  initial for (int i = 0; i < CMD_BITS; i++) pulse_cnt[i] = 0;
  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < CMD_BITS; i++) if (cmd_pulse[i]) pulse_cnt[i]++;
      if (awready) aw_hs_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic b_check;
    logic [1:0] e;
    if (exp_b_q.size() == 0) begin
      check_eq("b_unexpected", {30'b0, bresp}, 32'hFFFF_FFFF);
    end else begin
      e = exp_b_q.pop_front();
      check_eq("bresp", {30'b0, bresp}, {30'b0, e});
    end
  endtask

  task automatic r_check;
    logic [33:0] e;
    if (exp_r_q.size() == 0) begin
      check_eq("r_unexpected", rdata, 32'hFFFF_FFFF);
    end else begin
      e = exp_r_q.pop_front();
      check_eq("rdata", rdata, e[31:0]);
      check_eq("rresp", {30'b0, rresp}, {30'b0, e[33:32]});
    end
  endtask

  task automatic wait_b;
    int n = 0;
    while (!bvalid && n < TMO) begin tick(); n++; end
    if (bvalid) b_check();
    else begin check_eq("b_timeout", {31'b0, bvalid}, 32'd1); void'(exp_b_q.pop_front()); end
    tick();
  endtask

  task automatic wait_aw;
    int n = 0;
    do begin tick(); n++; end while (!awready && n < TMO);
    if (!awready) check_eq("aw_timeout", {31'b0, awready}, 32'd1);
  endtask

  task automatic axi_write(input int word, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp);
    exp_b_q.push_back(resp);
    awaddr = ADDR_W'(word * 4); wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    wait_aw();
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    wr_pulse = cmd_pulse;
    wait_b();
  endtask

  task automatic axi_read(input int word, input logic [31:0] ed, input logic [1:0] er);
    int n = 0;
    exp_r_q.push_back({er, ed});
    araddr = ADDR_W'(word * 4); arvalid = 1'b1;
    do begin tick(); n++; end while (!arready && n < TMO);
    if (!arready) check_eq("ar_timeout", {31'b0, arready}, 32'd1);
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < TMO) begin tick(); n++; end
    if (rvalid) r_check();
    else begin check_eq("r_timeout", {31'b0, rvalid}, 32'd1); void'(exp_r_q.pop_front()); end
    tick();
  endtask

  initial begin
    int base [CMD_BITS];
    int hs0, bv;
    logic [NUM_REGS*32-1:0] snap;

    rstn = 1'b0; awaddr = '0; araddr = '0; awvalid = 1'b0; wvalid = 1'b0;
    arvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b1; rready = 1'b1;
    status = '0; wr_pulse = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    tick();

    // Reset state
    check_eq("rst_outs", {26'b0, awready, wready, bvalid, arready, rvalid, |cmd_pulse}, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_resp", {28'b0, bresp, rresp}, 32'd0);
    check_eq("rst_cfg2", cfg[2*32 +: 32], VERSION);

    // Initial map
    axi_read(0, 32'd0, 2'b00);
    axi_read(1, 32'd0, 2'b00);
    axi_read(2, VERSION, 2'b00);
    axi_read(3, 32'd0, 2'b00);
    axi_read(4, 32'd0, 2'b00);

    // Batch size and loopback
    axi_write(19, 32'h0000_0004, 4'hF, 2'b00);
    check_eq("cfg19", cfg[19*32 +: 32], 32'h4);
    axi_write(20, 32'h0000_0001, 4'hF, 2'b00);
    check_eq("cfg20", cfg[20*32 +: 32], 32'h1);
    axi_read(19, 32'h4, 2'b00);
    axi_read(20, 32'h1, 2'b00);

    // Status word and read-only words
    status = 32'h1234_5678;
    axi_read(1, 32'h1234_5678, 2'b00);
    axi_write(1, 32'hFFFF_FFFF, 4'hF, 2'b00);
    axi_write(2, 32'hFFFF_FFFF, 4'hF, 2'b00);
    check_eq("cfg1_ro", cfg[1*32 +: 32], 32'd0);
    axi_read(2, VERSION, 2'b00);

    // Command strobes
    for (int i = 0; i < CMD_BITS; i++) base[i] = pulse_cnt[i];
    axi_write(0, 32'h1, 4'hF, 2'b00);
    check_eq("pulse_start_rec", {23'b0, wr_pulse}, 32'h001);
    axi_write(0, 32'h0, 4'hF, 2'b00);
    check_eq("pulse_zero_wr", {23'b0, wr_pulse}, 32'h000);
    axi_write(0, 32'h2, 4'hF, 2'b00);
    check_eq("pulse_stop_rec", {23'b0, wr_pulse}, 32'h002);
    axi_write(0, 32'h2, 4'hF, 2'b00);
    check_eq("pulse_repeat", {23'b0, wr_pulse}, 32'h000);
    check_eq("pulse0_cycles", 32'(pulse_cnt[0] - base[0]), 32'd1);
    check_eq("pulse1_cycles", 32'(pulse_cnt[1] - base[1]), 32'd1);
    axi_write(0, 32'h0, 4'hF, 2'b00);
    axi_write(0, 32'h3C1, 4'hF, 2'b00);
    check_eq("pulse_multi", {23'b0, wr_pulse}, 32'h1C1);
    check_eq("pulse8_cycles", 32'(pulse_cnt[8] - base[8]), 32'd1);
    axi_read(0, 32'h3C1, 2'b00);
    axi_write(0, 32'h0, 4'hF, 2'b00);

    // AW before W, BREADY held low, second write stalled behind B
    bready = 1'b0; hs0 = aw_hs_cnt;
    exp_b_q.push_back(2'b00);
    exp_b_q.push_back(2'b00);
    awaddr = ADDR_W'(7 * 4); wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1;
    repeat (5) tick();
    check_eq("aw_alone_no_hs", 32'(aw_hs_cnt - hs0), 32'd0);
    wvalid = 1'b1;
    wait_aw();
    tick();
    awaddr = ADDR_W'(8 * 4); wdata = 32'h88;
    bv = 0;
    for (int i = 0; i < 10; i++) begin if (bvalid) bv++; tick(); end
    check_eq("bvalid_hold", 32'(bv), 32'd10);
    check_eq("stall_one_hs", 32'(aw_hs_cnt - hs0), 32'd1);
    b_check();
    bready = 1'b1;
    tick();
    wait_aw();
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    wait_b();
    check_eq("stall_two_hs", 32'(aw_hs_cnt - hs0), 32'd2);
    axi_read(7, 32'h77, 2'b00);
    axi_read(8, 32'h88, 2'b00);

    // W before AW
    hs0 = aw_hs_cnt;
    exp_b_q.push_back(2'b00);
    wdata = 32'h99; wstrb = 4'hF; wvalid = 1'b1; awaddr = ADDR_W'(9 * 4);
    repeat (5) tick();
    check_eq("w_alone_no_hs", 32'(aw_hs_cnt - hs0), 32'd0);
    awvalid = 1'b1;
    wait_aw();
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    wait_b();
    axi_read(9, 32'h99, 2'b00);

    // Byte strobes
    axi_write(5, 32'h0002_0003, 4'hF, 2'b00);
    axi_write(5, 32'hAABB_CCDD, 4'b0010, 2'b00);
    axi_read(5, 32'h0002_CC03, 2'b00);

    // Out of range
    snap = cfg;
    axi_write(40, 32'hDEAD_BEEF, 4'hF, 2'b10);
    check_eq("oor_no_change", 32'(cfg == snap), 32'd1);
    axi_read(40, 32'd0, 2'b10);

    // Same-cycle read and write of one word returns the old value
    axi_write(10, 32'h11, 4'hF, 2'b00);
    exp_b_q.push_back(2'b00);
    exp_r_q.push_back({2'b00, 32'h11});
    awaddr = ADDR_W'(10 * 4); araddr = ADDR_W'(10 * 4); wdata = 32'h22; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    wait_aw();
    check_eq("same_cycle_ar", {31'b0, arready}, 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    if (rvalid) r_check(); else check_eq("same_cycle_rvalid", {31'b0, rvalid}, 32'd1);
    wait_b();
    axi_read(10, 32'h22, 2'b00);

    // Reset with both responses pending
    bready = 1'b0; rready = 1'b0;
    awaddr = ADDR_W'(11 * 4); araddr = ADDR_W'(3 * 4); wdata = 32'h55; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    wait_aw();
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check_eq("pre_rst_valids", {30'b0, bvalid, rvalid}, 32'd3);
    #2 rstn = 1'b0;
    #1;
    check_eq("rst_async_valids", {30'b0, bvalid, rvalid}, 32'd0);
    check_eq("rst_cfg11", cfg[11*32 +: 32], 32'd0);
    check_eq("rst_cfg19", cfg[19*32 +: 32], 32'd0);
    @(negedge clk) rstn = 1'b1;
    bready = 1'b1; rready = 1'b1;
    tick();
    axi_read(19, 32'd0, 2'b00);
    axi_write(11, 32'h66, 4'hF, 2'b00);
    axi_read(11, 32'h66, 2'b00);

    check_eq("sb_drained", 32'(exp_b_q.size() + exp_r_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
